stage4_hazard_unit: RTL and testbench

STAGE4_HAZARD_UNIT -- requirements
Module: stage4_hazard_unit

---
 rtl/rv32i_types_pkg.sv | 9 +
 rtl/stage4_types_pkg.sv | 21 ++
 rtl/stage4_flush_timer.sv | 37 +++
 rtl/stage4_hazard_unit.sv | 193 +++++++++++++++++++
 tb/tb_stage4_hazard_unit.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I datapath types used by the stage-4 pipeline control blocks.
package rv32i_types_pkg;

    typedef logic [4:0]  regsel_t;
    typedef logic [31:0] word_t;

    localparam regsel_t REG_ZERO = 5'd0;

endpackage

// File: rtl/stage4_types_pkg.sv
// Types and helpers for the stage-4 hazard unit: controller state and flush-timer width.
package stage4_types_pkg;

    import rv32i_types_pkg::*;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        FLUSH   = 2'd2,
        REFETCH = 2'd3
    } hazard_state_t;

    localparam int unsigned FLUSH_CNT_W = 16;
    typedef logic [FLUSH_CNT_W-1:0] flush_cnt_t;

    // True when the mem-stage destination feeds either execute-stage source.
    function automatic logic reg_match(regsel_t rd, regsel_t rs1, regsel_t rs2);
        return (rd == rs1) || (rd == rs2);
    endfunction

endpackage

// File: rtl/stage4_flush_timer.sv
// Loadable up-counter with terminal-count flag; bounds how long a cache flush may take.
module stage4_flush_timer
    import stage4_types_pkg::*;
#(
    parameter flush_cnt_t TERMINAL = flush_cnt_t'(1023)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    flush_cnt_t cnt_q;
    flush_cnt_t cnt_d;

    // Holds at TERMINAL so a late consumer never sees the count wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != TERMINAL)) begin
            cnt_d = cnt_q + flush_cnt_t'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && (cnt_q == TERMINAL);

endmodule

// File: rtl/stage4_hazard_unit.sv
// Stage-4 pipeline hazard/stall/flush controller with fence.i cache-flush sequencing.
// Optional performance counters are enabled by defining STAGE4_HAZARD_PERF_EN.
module stage4_hazard_unit
    import rv32i_types_pkg::*;
    import stage4_types_pkg::*;
#(
    parameter int unsigned FLUSH_TIMEOUT = 1024
) (
    input  logic          CLK,
    input  logic          nRST,
    input  regsel_t       rs1_e,
    input  regsel_t       rs2_e,
    input  regsel_t       rd_m,
    input  logic          reg_write_m,
    input  logic          load_m,
    input  logic          dmem_req,
    input  logic          dmem_done,
    input  logic          imem_done,
    input  logic          mispredict,
    input  logic          exception,
    input  logic          fence_i_e,
    input  logic          cache_flush_done,
    output logic          stall_fetch,
    output logic          stall_execute,
    output logic          stall_mem,
    output logic          flush_fetch,
    output logic          flush_execute,
    output logic          cache_flush_req,
    output logic          fencei_redirect,
    output logic          fence_error,
    output hazard_state_t state_dbg
`ifdef STAGE4_HAZARD_PERF_EN
    ,
    output word_t         stall_cycles,
    output word_t         flush_count
`endif
);

    localparam flush_cnt_t FLUSH_TC = flush_cnt_t'(FLUSH_TIMEOUT - 1);

    hazard_state_t state_q;
    hazard_state_t state_d;
    logic          fence_error_q;
    logic          fence_error_d;
    logic          cache_flush_req_q;

    logic in_flush;
    logic timeout;
    logic dmem_busy;
    logic load_use;
    logic redirect;

    logic stall_fetch_c;
    logic stall_execute_c;
    logic stall_mem_c;
    logic flush_fetch_c;
    logic flush_execute_c;
    logic fencei_redirect_c;

    assign in_flush  = (state_q == FLUSH);
    assign dmem_busy = dmem_req & ~dmem_done;
    assign load_use  = load_m & reg_write_m & (rd_m != REG_ZERO)
                     & reg_match(rd_m, rs1_e, rs2_e) & ~dmem_done;
    // Caches must finish once started, so redirects are deaf while flushing.
    assign redirect  = (exception | mispredict) & ~in_flush;

    stage4_flush_timer #(
        .TERMINAL(FLUSH_TC)
    ) u_flush_timer (
        .clk_i (CLK),
        .rst_ni(nRST),
        .load_i(~in_flush),
        .en_i  (in_flush),
        .tc_o  (timeout)
    );

    // Any redirect while draining kills the fence.i still held in execute.
    always_comb begin
        state_d       = state_q;
        fence_error_d = fence_error_q;
        case (state_q)
            RUN: begin
                if (!redirect && fence_i_e) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    state_d = RUN;
                end else if (!dmem_req || dmem_done) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (cache_flush_done) begin
                    state_d = REFETCH;
                end else if (timeout) begin
                    state_d       = REFETCH;
                    fence_error_d = 1'b1;
                end
            end
            REFETCH: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // cache_flush_req is a level request held for every FLUSH cycle; the caches
    // answer with a one-cycle cache_flush_done, and the request drops the cycle after.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q           <= RUN;
            fence_error_q     <= 1'b0;
            cache_flush_req_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            fence_error_q     <= fence_error_d;
            cache_flush_req_q <= (state_d == FLUSH);
        end
    end

    always_comb begin
        stall_fetch_c     = 1'b0;
        stall_execute_c   = 1'b0;
        stall_mem_c       = 1'b0;
        flush_fetch_c     = 1'b0;
        flush_execute_c   = 1'b0;
        fencei_redirect_c = 1'b0;
        case (state_q)
            RUN: begin
                stall_execute_c = load_use | dmem_busy;
                stall_mem_c     = dmem_busy;
                stall_fetch_c   = stall_execute_c | ~imem_done;
                flush_execute_c = ~imem_done & ~stall_execute_c;
            end
            DRAIN: begin
                stall_fetch_c   = 1'b1;
                stall_execute_c = 1'b1;
                stall_mem_c     = dmem_busy;
            end
            FLUSH: begin
                stall_fetch_c   = 1'b1;
                stall_execute_c = 1'b1;
            end
            REFETCH: begin
                flush_fetch_c     = 1'b1;
                flush_execute_c   = 1'b1;
                fencei_redirect_c = 1'b1;
            end
            default: ;
        endcase
        // An unfinished data access must still hold mem even under a redirect.
        if (redirect) begin
            stall_fetch_c   = 1'b0;
            stall_execute_c = 1'b0;
            stall_mem_c     = dmem_busy;
            flush_fetch_c   = 1'b1;
            flush_execute_c = 1'b1;
        end
    end

    assign stall_fetch     = nRST & stall_fetch_c;
    assign stall_execute   = nRST & stall_execute_c;
    assign stall_mem       = nRST & stall_mem_c;
    assign flush_fetch     = nRST & flush_fetch_c;
    assign flush_execute   = nRST & flush_execute_c;
    assign fencei_redirect = nRST & fencei_redirect_c;
    assign cache_flush_req = cache_flush_req_q;
    assign fence_error     = fence_error_q;
    assign state_dbg       = state_q;

`ifdef STAGE4_HAZARD_PERF_EN
    word_t stall_cycles_q;
    word_t flush_count_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall_execute && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + word_t'(1);
            end
            if (flush_execute && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + word_t'(1);
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_stage4_hazard_unit.sv
// Scoreboard bench for stage4_hazard_unit: per-cycle expected outputs from a reference model.
module tb_stage4_hazard_unit;

    import rv32i_types_pkg::*;
    import stage4_types_pkg::*;

    localparam int unsigned T = 8;

    logic          CLK = 1'b0;
    logic          nRST;
    regsel_t       rs1_e, rs2_e, rd_m;
    logic          reg_write_m, load_m, dmem_req, dmem_done, imem_done;
    logic          mispredict, exception, fence_i_e, cache_flush_done;
    logic          stall_fetch, stall_execute, stall_mem, flush_fetch, flush_execute;
    logic          cache_flush_req, fencei_redirect, fence_error;
    hazard_state_t state_dbg;
`ifdef STAGE4_HAZARD_PERF_EN
    word_t         stall_cycles, flush_count;
`endif

    stage4_hazard_unit #(.FLUSH_TIMEOUT(T)) dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .rs1_e           (rs1_e),
        .rs2_e           (rs2_e),
        .rd_m            (rd_m),
        .reg_write_m     (reg_write_m),
        .load_m          (load_m),
        .dmem_req        (dmem_req),
        .dmem_done       (dmem_done),
        .imem_done       (imem_done),
        .mispredict      (mispredict),
        .exception       (exception),
        .fence_i_e       (fence_i_e),
        .cache_flush_done(cache_flush_done),
        .stall_fetch     (stall_fetch),
        .stall_execute   (stall_execute),
        .stall_mem       (stall_mem),
        .flush_fetch     (flush_fetch),
        .flush_execute   (flush_execute),
        .cache_flush_req (cache_flush_req),
        .fencei_redirect (fencei_redirect),
        .fence_error     (fence_error),
        .state_dbg       (state_dbg)
`ifdef STAGE4_HAZARD_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    // ---------------- clock / watchdog ----------------
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    // ---------------- stimulus record ----------------
    typedef struct packed {
        logic       rstn;
        logic [4:0] rs1, rs2, rd;
        logic       rw, ld, dreq, ddone, idone, mp, exc, fi, cfd;
    } stim_t;

    logic [9:0] exp_q[$];
    string      tag_q[$];
    int         checks = 0;
    int         fails  = 0;

    // ---------------- reference model ----------------
    hazard_state_t m_state = RUN;
    int            m_flush_cycles = 0;
    logic          m_err = 1'b0;
    int            m_stall_cnt = 0;
    int            m_flush_cnt = 0;

    function automatic stim_t idle();
        stim_t s = '0;
        s.rstn  = 1'b1;
        s.idone = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rstn  = ($urandom_range(0, 99) != 0);
        s.rs1   = 5'($urandom_range(0, 3));
        s.rs2   = 5'($urandom_range(0, 3));
        s.rd    = 5'($urandom_range(0, 3));
        s.rw    = 1'($urandom_range(0, 1));
        s.ld    = 1'($urandom_range(0, 1));
        s.dreq  = ($urandom_range(0, 2) == 0);
        s.ddone = ($urandom_range(0, 2) == 0);
        s.idone = ($urandom_range(0, 4) != 0);
        s.mp    = ($urandom_range(0, 15) == 0);
        s.exc   = ($urandom_range(0, 19) == 0);
        s.fi    = ($urandom_range(0, 5) == 0);
        s.cfd   = ($urandom_range(0, 5) == 0);
        return s;
    endfunction

    // Expected outputs for this cycle, then advance to the state after the next edge.
    task automatic model_step(input stim_t s, output logic [9:0] e);
        logic sf, se, sm, ff, fe, rdr, redir, busy, hit;
        if (!s.rstn) begin
            m_state        = RUN;
            m_flush_cycles = 0;
            m_err          = 1'b0;
            m_stall_cnt    = 0;
            m_flush_cnt    = 0;
            e = {8'b0, RUN};
            return;
        end
        busy  = s.dreq && !s.ddone;
        hit   = s.ld && s.rw && (s.rd != 0) && ((s.rd == s.rs1) || (s.rd == s.rs2)) && !s.ddone;
        redir = (s.exc || s.mp) && (m_state != FLUSH);
        sf = 0; se = 0; sm = 0; ff = 0; fe = 0; rdr = 0;
        if (m_state == RUN) begin
            se = hit || busy;
            sm = busy;
            sf = se || !s.idone;
            fe = !s.idone && !se;
        end else if (m_state == DRAIN) begin
            sf = 1; se = 1; sm = busy;
        end else if (m_state == FLUSH) begin
            sf = 1; se = 1;
        end else begin
            ff = 1; fe = 1; rdr = 1;
        end
        if (redir) begin
            sf = 0; se = 0; sm = busy; ff = 1; fe = 1;
        end
        e = {sf, se, sm, ff, fe, (m_state == FLUSH), rdr, m_err, m_state};
        if (se) m_stall_cnt++;
        if (fe) m_flush_cnt++;
        case (m_state)
            RUN:     if (!redir && s.fi) m_state = DRAIN;
            DRAIN: begin
                if (redir) m_state = RUN;
                else if (!s.dreq || s.ddone) begin
                    m_state        = FLUSH;
                    m_flush_cycles = 0;
                end
            end
            FLUSH: begin
                if (s.cfd) m_state = REFETCH;
                else if (m_flush_cycles + 1 == int'(T)) begin
                    m_state = REFETCH;
                    m_err   = 1'b1;
                end else m_flush_cycles++;
            end
            default: m_state = RUN;
        endcase
    endtask

    // ---------------- driver ----------------
    task automatic step(input stim_t s, input string tag);
        logic [9:0] e;
        @(negedge CLK);
        nRST             = s.rstn;
        rs1_e            = s.rs1;
        rs2_e            = s.rs2;
        rd_m             = s.rd;
        reg_write_m      = s.rw;
        load_m           = s.ld;
        dmem_req         = s.dreq;
        dmem_done        = s.ddone;
        imem_done        = s.idone;
        mispredict       = s.mp;
        exception        = s.exc;
        fence_i_e        = s.fi;
        cache_flush_done = s.cfd;
        model_step(s, e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // done_at = 0: never complete the flush, forcing the timeout path.
    task automatic run_fence(input int done_at, input string tag);
        stim_t s;
        int    n;
        s = idle();
        s.fi = 1'b1;
        step(s, {tag, "_enter"});
        step(s, {tag, "_drain"});
        n = (done_at == 0) ? int'(T) : done_at;
        for (int i = 1; i <= n; i++) begin
            s.cfd = (i == done_at);
            step(s, {tag, "_flush"});
        end
        s.cfd = 1'b0;
        step(s, {tag, "_refetch"});
        s.fi = 1'b0;
        step(s, {tag, "_run"});
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [9:0] mon_exp, mon_act;
    string      mon_tag;

    always @(negedge CLK) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_act = {stall_fetch, stall_execute, stall_mem, flush_fetch, flush_execute,
                       cache_flush_req, fencei_redirect, fence_error, state_dbg};
            checks++;
            if (mon_act !== mon_exp) begin
                fails++;
                $display("FAIL %s @%0t: got %b want %b (sf se sm ff fe cfr rdr err st)",
                         mon_tag, $time, mon_act, mon_exp);
            end
        end
    end

`ifdef STAGE4_HAZARD_PERF_EN
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask
`endif

    // ---------------- test sequence ----------------
    initial begin
        stim_t s;
        nRST = 1'b0; rs1_e = '0; rs2_e = '0; rd_m = '0;
        reg_write_m = 0; load_m = 0; dmem_req = 0; dmem_done = 0; imem_done = 1;
        mispredict = 0; exception = 0; fence_i_e = 0; cache_flush_done = 0;

        for (int i = 0; i < 3; i++) begin
            s = rand_stim();
            s.rstn = 1'b0;
            step(s, "reset");
        end

        s = idle(); s.ld = 1; s.rw = 1; s.rd = 5; s.rs2 = 5; s.rs1 = 1; s.dreq = 1;
        repeat (3) step(s, "load_use_wait");
        s.ddone = 1;
        step(s, "load_use_done");
        s.rd = 0; s.ddone = 0; s.dreq = 0;
        repeat (2) step(s, "load_use_rd_zero");

        s = idle(); s.idone = 0;
        step(s, "imem_bubble");
        s.dreq = 1;
        step(s, "imem_under_dmem_stall");

        s = idle(); s.ld = 1; s.rw = 1; s.rd = 3; s.rs1 = 3; s.exc = 1; s.mp = 1;
        step(s, "redirect_over_load_use");
        s.dreq = 1;
        step(s, "redirect_keeps_stall_mem");

        run_fence(4, "fence_done4");
        run_fence(int'(T), "fence_done_at_timeout");
        run_fence(0, "fence_timeout");
        repeat (3) step(idle(), "error_sticky");
        s = idle(); s.rstn = 0;
        step(s, "error_cleared_by_reset");
        step(idle(), "after_reset");

        s = idle(); s.fi = 1;
        step(s, "rst_mid_flush_enter");
        step(s, "rst_mid_flush_drain");
        repeat (2) step(s, "rst_mid_flush_flush");
        s.rstn = 0;
        step(s, "rst_mid_flush_async");
        repeat (2) step(idle(), "rst_mid_flush_after");

        s = idle(); s.fi = 1; s.dreq = 1;
        step(s, "exc_drain_enter");
        step(s, "exc_drain_wait");
        s.exc = 1;
        step(s, "exc_drain_abort");
        step(idle(), "exc_drain_run");

        s = idle(); s.fi = 1;
        step(s, "exc_flush_enter");
        step(s, "exc_flush_drain");
        s.exc = 1; s.mp = 1;
        repeat (2) step(s, "exc_flush_ignored");
        s.exc = 0; s.mp = 0; s.cfd = 1;
        step(s, "exc_flush_done");
        s.cfd = 0; s.fi = 0;
        step(s, "exc_flush_refetch");
        step(idle(), "exc_flush_run");

`ifdef STAGE4_HAZARD_PERF_EN
        s = idle(); s.rstn = 0;
        step(s, "perf_reset");
        s = idle(); s.dreq = 1;
        repeat (10) step(s, "perf_stall");
        s = idle(); s.exc = 1;
        repeat (2) step(s, "perf_flush");
        @(posedge CLK); #1;
        chk("perf_stall_cycles_10", stall_cycles, 32'd10);
        chk("perf_flush_count_2", flush_count, 32'd2);
`endif

        for (int i = 0; i < 600; i++) step(rand_stim(), "random");

        repeat (2) @(negedge CLK);
        #3;
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
`ifdef STAGE4_HAZARD_PERF_EN
        chk("perf_stall_cycles_model", stall_cycles, 32'(m_stall_cnt));
        chk("perf_flush_count_model", flush_count, 32'(m_flush_cnt));
`endif
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
